// File: rtl/ldl_fifo_arb_pkg.sv
// Shared types and helpers for the ldl FIFO write-side arbiters.
package ldl_fifo_arb_pkg;

    // Arbiter FSM: waiting to grant, or holding a grant for up to BURST beats.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits (N==1 still gets one bit).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldl_rr_pick_v1.sv
// Circular first-one finder: returns the first set bit of req scanning
// ptr, ptr+1 .. N-1, 0 .. ptr-1. Purely combinational, reusable by any arbiter.
module ldl_rr_pick_v1 #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          hit
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate req so bit 0 is the ptr position, then take the lowest set bit and map it back.
    always_comb begin
        rot = N'({req, req} >> ptr);
        idx = '0;
        hit = 1'b0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (IW + 1)'(k);
                if (sum >= (IW + 1)'(N)) begin
                    sum = sum - (IW + 1)'(N);
                end
                idx = sum[IW-1:0];
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldl_fifo_wr_arb_v1.sv
// Round-robin burst arbiter for the write side of one async FIFO.
// Optional build macro: LDL_FIFO_WR_ARB_PRIO0_EN makes requester 0 strict priority.
//
// Handshake: requester i raises req[i] with din slice i valid and holds both stable
// until ack[i] pulses; ack[i] marks the cycle its word is written into the FIFO.
// Dropping req[i] before ack simply ends that requester's burst.
module ldl_fifo_wr_arb_v1
    import ldl_fifo_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DW    = 8,
    parameter  int BURST = 4,
    localparam int IW    = clog2_min1(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*DW-1:0]   din,
    output logic [N-1:0]      ack,
    output logic [IW-1:0]     owner,
    output logic              busy,
    input  logic              fifo_full,
    output logic              fifo_we,
    output logic [IW+DW-1:0]  fifo_din
);

    localparam int BW = $clog2(BURST) + 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, owner_q, ptr_next;
    logic [BW-1:0]   beat_q;
    logic [N-1:0]    pick_req;
    logic [IW-1:0]   pick_idx, grant_idx;
    logic            pick_hit, grant_hit;
    logic            own_req, wr, leave;
    logic [DW-1:0]   own_data;

    ldl_rr_pick_v1 #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    // Grant selection: round-robin, optionally with requester 0 jumping the queue.
    always_comb begin
`ifdef LDL_FIFO_WR_ARB_PRIO0_EN
        pick_req  = req & ~N'(1);
        grant_hit = |req;
        grant_idx = req[0] ? '0 : pick_idx;
`else
        pick_req  = req;
        grant_hit = pick_hit;
        grant_idx = pick_idx;
`endif
    end

    // Owner's request and data, plus the write/leave decisions for this cycle.
    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                own_req  = req[i];
                own_data = din[i*DW +: DW];
            end
        end
        wr       = (state_q == ST_BURST) && own_req && !fifo_full;
        leave    = (state_q == ST_BURST) &&
                   (!own_req || (wr && (beat_q == BW'(BURST - 1))));
        ptr_next = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a grant always costs one IDLE cycle before the next one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_hit) state_d = ST_BURST;
            ST_BURST: if (leave)     state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Owner capture, beat counting and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
        end else if (state_q == ST_IDLE) begin
            if (grant_hit) begin
                owner_q <= grant_idx;
                beat_q  <= '0;
            end
        end else if (leave) begin
            beat_q <= '0;
`ifdef LDL_FIFO_WR_ARB_PRIO0_EN
            if (owner_q != '0) begin
                ptr_q <= ptr_next;
            end
`else
            ptr_q <= ptr_next;
`endif
        end else if (wr) begin
            beat_q <= beat_q + BW'(1);
        end
    end

    // Outputs: write strobe and ack come straight from the registered owner.
    always_comb begin
        ack = '0;
        for (int i = 0; i < N; i++) begin
            if (wr && (owner_q == IW'(i))) begin
                ack[i] = 1'b1;
            end
        end
        fifo_we  = wr;
        fifo_din = {owner_q, own_data};
        owner    = owner_q;
        busy     = (state_q == ST_BURST);
    end

endmodule

// File: tb/tb_ldl_fifo_wr_arb_v1.sv
// Directed testbench for ldl_fifo_wr_arb_v1 (N=4, DW=8, BURST=4).
module tb_ldl_fifo_wr_arb_v1;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int W  = IW + DW;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din;
    logic [N-1:0]    ack;
    logic [IW-1:0]   owner;
    logic            busy;
    logic            fifo_full;
    logic            fifo_we;
    logic [W-1:0]    fifo_din;

    int n_chk;
    int n_fail;

    // Collector results from run_bursts
    int           n_wr;
    int           burst_q[$];
    int           gap_q[$];
    int           owner_q[$];
    logic [W-1:0] obs_q[$];
    logic [W-1:0] exp_q[$];

    logic [DW-1:0] dv [N];

    ldl_fifo_wr_arb_v1 #(
        .N     (N),
        .DW    (DW),
        .BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .owner     (owner),
        .busy      (busy),
        .fifo_full (fifo_full),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- driver / collector ----------------
    // Runs a bounded number of cycles, recording bursts, idle gaps, owners and written words.
    // Drops req once stop_writes words have been written (0 = never).
    task automatic run_bursts(input int cycles, input int stop_writes);
        int cur;
        int gap;
        bit in_b;
        bit seen;
        cur = 0; gap = 0; in_b = 0; seen = 0; n_wr = 0;
        burst_q.delete(); gap_q.delete(); owner_q.delete(); obs_q.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (busy) begin
                if (!in_b) begin
                    owner_q.push_back(int'(owner));
                    if (seen) gap_q.push_back(gap);
                    in_b = 1;
                end
                if (fifo_we) begin
                    cur++;
                    n_wr++;
                    obs_q.push_back(fifo_din);
                end
            end else begin
                if (in_b) begin
                    burst_q.push_back(cur);
                    cur = 0; in_b = 0; seen = 1; gap = 0;
                end
                gap++;
            end
            @(posedge clk);
            #1;
            if (stop_writes > 0 && n_wr == stop_writes) req = '0;
        end
        if (in_b) burst_q.push_back(cur);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit got_we;
        int o;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (ack !== '0)     begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_chk++; if (fifo_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", fifo_we); end
        n_chk++; if (owner !== '0)   begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        @(posedge clk); #1;
        rst = 1'b1;
        // A full owner-2 burst moves ptr to 3
        req = 4'b0100;
        run_bursts(7, 4);
        o = (owner_q.size() > 0) ? owner_q[0] : -1;
        n_chk++; if (o != 2) begin n_fail++; $display("FAIL reset_pre_owner got=%0d exp=2", o); end
        // Start an owner-3 burst and reset in the middle of it
        req = 4'b1000;
        got_we = 0;
        for (int c = 0; c < 10 && !got_we; c++) begin
            @(negedge clk);
            if (fifo_we) got_we = 1;
        end
        n_chk++; if (!got_we) begin n_fail++; $display("FAIL reset_wait_we got=timeout exp=write"); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
        n_chk++; if (ack !== '0)       begin n_fail++; $display("FAIL reset_mid_ack got=%b exp=0000", ack); end
        n_chk++; if (fifo_we !== 1'b0) begin n_fail++; $display("FAIL reset_mid_we got=%b exp=0", fifo_we); end
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1111;
        run_bursts(3, 0);
        o = (owner_q.size() > 0) ? owner_q[0] : -1;
        n_chk++; if (o != 0) begin n_fail++; $display("FAIL reset_ptr_owner got=%0d exp=0", o); end
        req = '0;
    endtask

    task automatic test_single_req();
        int exp_b [3] = '{4, 4, 2};
        int bad;
        do_reset();
        req = 4'b0001;
        run_bursts(20, 10);
        n_chk++; if (n_wr != 10) begin n_fail++; $display("FAIL single_writes got=%0d exp=10", n_wr); end
        n_chk++; if (burst_q.size() != 3) begin n_fail++; $display("FAIL single_nbursts got=%0d exp=3", burst_q.size()); end
        for (int i = 0; i < 3 && i < burst_q.size(); i++) begin
            n_chk++;
            if (burst_q[i] != exp_b[i]) begin
                n_fail++; $display("FAIL single_burst%0d got=%0d exp=%0d", i, burst_q[i], exp_b[i]);
            end
        end
        n_chk++; if (gap_q.size() != 2) begin n_fail++; $display("FAIL single_ngaps got=%0d exp=2", gap_q.size()); end
        for (int i = 0; i < gap_q.size(); i++) begin
            n_chk++;
            if (gap_q[i] != 1) begin n_fail++; $display("FAIL single_gap%0d got=%0d exp=1", i, gap_q[i]); end
        end
        bad = 0;
        foreach (obs_q[i]) if (obs_q[i] !== {2'd0, dv[0]}) bad++;
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL single_tagdata got=%0d_bad_words exp=0", bad); end
    endtask

    task automatic test_all_req();
        int exp_o [5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] e;
        do_reset();
        exp_q.delete();
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++) exp_q.push_back({IW'(exp_o[b]), dv[exp_o[b]]});
        req = 4'b1111;
        run_bursts(30, 20);
        n_chk++; if (owner_q.size() != 5) begin n_fail++; $display("FAIL all_nbursts got=%0d exp=5", owner_q.size()); end
        for (int i = 0; i < 5 && i < owner_q.size(); i++) begin
            n_chk++;
            if (owner_q[i] != exp_o[i]) begin n_fail++; $display("FAIL all_owner%0d got=%0d exp=%0d", i, owner_q[i], exp_o[i]); end
        end
        foreach (burst_q[i]) begin
            n_chk++;
            if (burst_q[i] != 4) begin n_fail++; $display("FAIL all_len%0d got=%0d exp=4", i, burst_q[i]); end
        end
        n_chk++; if (obs_q.size() != 20) begin n_fail++; $display("FAIL all_nwords got=%0d exp=20", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q[0] !== e) begin n_fail++; $display("FAIL all_word got=%h exp=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
    endtask

    task automatic test_full_stall();
        bit e_full [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        bit e_we   [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        bit e_busy [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int writes;
        do_reset();
        req = 4'b0100;
        writes = 0;
        for (int i = 0; i < 9; i++) begin
            fifo_full = e_full[i];
            @(negedge clk);
            if (fifo_we) writes++;
            n_chk++; if (fifo_we !== e_we[i]) begin n_fail++; $display("FAIL full_we c%0d got=%b exp=%b", i, fifo_we, e_we[i]); end
            n_chk++; if (busy !== e_busy[i]) begin n_fail++; $display("FAIL full_busy c%0d got=%b exp=%b", i, busy, e_busy[i]); end
            n_chk++; if (ack !== (e_we[i] ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL full_ack c%0d got=%b exp=%b", i, ack, e_we[i] ? 4'b0100 : 4'b0000); end
            if (e_busy[i]) begin
                n_chk++; if (owner !== 2'd2) begin n_fail++; $display("FAIL full_owner c%0d got=%0d exp=2", i, owner); end
            end
            @(posedge clk); #1;
        end
        n_chk++; if (writes != 4) begin n_fail++; $display("FAIL full_writes got=%0d exp=4", writes); end
        req = '0;
        fifo_full = 1'b0;
    endtask

    task automatic test_drop_req();
        logic [N-1:0] r_v [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
        bit e_busy [6] = '{0, 1, 1, 1, 0, 1};
        bit e_we   [6] = '{0, 1, 1, 0, 0, 1};
        int e_own  [6] = '{0, 1, 1, 1, 0, 3};
        logic [N-1:0] e_ack;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = r_v[i];
            @(negedge clk);
            e_ack = e_we[i] ? (4'b0001 << e_own[i]) : 4'b0000;
            n_chk++; if (busy !== e_busy[i]) begin n_fail++; $display("FAIL drop_busy c%0d got=%b exp=%b", i, busy, e_busy[i]); end
            n_chk++; if (fifo_we !== e_we[i]) begin n_fail++; $display("FAIL drop_we c%0d got=%b exp=%b", i, fifo_we, e_we[i]); end
            n_chk++; if (ack !== e_ack) begin n_fail++; $display("FAIL drop_ack c%0d got=%b exp=%b", i, ack, e_ack); end
            if (e_busy[i]) begin
                n_chk++; if (int'(owner) != e_own[i]) begin n_fail++; $display("FAIL drop_owner c%0d got=%0d exp=%0d", i, owner, e_own[i]); end
            end
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_ptr_order();
        logic [N-1:0] r_v [3] = '{4'b0101, 4'b0110, 4'b1110};
`ifdef LDL_FIFO_WR_ARB_PRIO0_EN
        int e_own [3] = '{0, 2, 3};
`else
        int e_own [3] = '{2, 1, 2};
`endif
        int o;
        do_reset();
        // One owner-1 write then drop: ptr becomes 2
        req = 4'b0010;
        run_bursts(4, 1);
        for (int p = 0; p < 3; p++) begin
            req = r_v[p];
            run_bursts(8, 4);
            o = (owner_q.size() > 0) ? owner_q[0] : -1;
            n_chk++; if (o != e_own[p]) begin n_fail++; $display("FAIL ptr_owner%0d got=%0d exp=%0d", p, o, e_own[p]); end
            n_chk++; if (n_wr != 4) begin n_fail++; $display("FAIL ptr_writes%0d got=%0d exp=4", p, n_wr); end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        dv[0] = 8'hA0; dv[1] = 8'hB1; dv[2] = 8'hC2; dv[3] = 8'hD3;
        din   = {dv[3], dv[2], dv[1], dv[0]};
        test_reset();
        test_single_req();
        test_all_req();
        test_full_stall();
        test_drop_req();
        test_ptr_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
